// File: rtl/line_rotate_ctrl_if.sv
// Upstream raster pixel stream: valid/ready handshake with a start-of-frame marker.
interface line_rotate_ctrl_if;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] din;
    logic       in_ready;

    modport master (output in_valid, output in_sof, output din, input in_ready);
    modport slave  (input in_valid, input in_sof, input din, output in_ready);
endinterface

// File: rtl/line_rotate_ctrl.sv
// Sequencer for a 5-line vertical window: rotates line-buffer write slots,
// drives window validin/hsel and flushes the window pipeline after each frame.
module line_rotate_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int AW     = 10,
    parameter int RW     = 10
) (
    input  logic                clock,
    input  logic                reset,
    line_rotate_ctrl_if.slave   pix,
    output logic [4:0]          wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [7:0]          wr_data,
    output logic [AW-1:0]       rd_addr,
    output logic [2:0]          hsel,
    output logic                win_valid,
    output logic                frame_done,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t         state;
    logic [AW-1:0]  col;
    logic [RW-1:0]  row;
    logic [2:0]     wp;
    logic [2:0]     flush_cnt;

    logic           xfer;
    logic           start;
    logic [AW-1:0]  cur_col;
    logic [RW-1:0]  cur_row;
    logic [2:0]     cur_wp;
    logic [2:0]     next_wp;
    logic [4:0]     slot_sel;
    logic           last_col;
    logic           last_row;
    logic           run_row;

    assign pix.in_ready = (state != FLUSH);
    assign xfer         = pix.in_valid & pix.in_ready;
    assign start        = xfer & pix.in_sof;

    // A start-of-frame pixel (from any non-flush state) is handled as row 0, col 0, slot 0.
    assign cur_col  = start ? '0   : col;
    assign cur_row  = start ? '0   : row;
    assign cur_wp   = start ? 3'd0 : wp;
    assign next_wp  = (cur_wp == 3'd4) ? 3'd0 : cur_wp + 3'd1;
    assign last_col = (cur_col == AW'(WIDTH - 1));
    assign last_row = (cur_row == RW'(HEIGHT - 1));
    assign run_row  = (cur_row >= RW'(4));

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_slot
            assign slot_sel[gi] = (cur_wp == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            wp         <= 3'd0;
            flush_cnt  <= 3'd0;
            wr_en      <= 5'd0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_data    <= 8'd0;
            hsel       <= 3'd0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_en      <= 5'd0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;

            if (state == FLUSH) begin
                // Five validin-only cycles push the last lines through the window, then report done.
                if (flush_cnt == 3'd5) begin
                    state      <= IDLE;
                    flush_cnt  <= 3'd0;
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                end else begin
                    flush_cnt <= flush_cnt + 3'd1;
                    win_valid <= 1'b1;
                end
            end else if (xfer && (start || state != IDLE)) begin
                wr_en   <= slot_sel;
                wr_addr <= cur_col;
                rd_addr <= cur_col;
                wr_data <= pix.din;
                busy    <= 1'b1;
                if (run_row) begin
                    win_valid <= 1'b1;
                    hsel      <= next_wp;
                end

                if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        state <= FLUSH;
                        row   <= '0;
                        wp    <= 3'd0;
                    end else begin
                        row   <= cur_row + RW'(1);
                        wp    <= next_wp;
                        state <= (cur_row >= RW'(3)) ? RUN : FILL;
                    end
                end else begin
                    col   <= cur_col + AW'(1);
                    row   <= cur_row;
                    wp    <= cur_wp;
                    state <= run_row ? RUN : FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_rotate_ctrl.sv
// Directed, table-driven check of line_rotate_ctrl on an 8x6 frame.
module tb_line_rotate_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = 4;
    localparam int RW = 4;

    typedef struct {
        logic          valid;
        logic          sof;
        logic [7:0]    din;
        logic [4:0]    wr_en;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          win;
        logic [2:0]    hsel;
        logic          rdy;
        logic          done;
        logic          busy;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    wr_data;
    logic [2:0]    hsel;
    logic          win_valid;
    logic          frame_done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    vec_t          vq[$];
    logic [AW-1:0] h_addr;
    logic [7:0]    h_data;
    logic [2:0]    h_hsel;
    int            frame_id = 0;

    always #5 clock = ~clock;

    line_rotate_ctrl_if pix ();

    line_rotate_ctrl #(.WIDTH(W), .HEIGHT(H), .AW(AW), .RW(RW)) dut (
        .clock      (clock),
        .reset      (reset),
        .pix        (pix),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .hsel       (hsel),
        .win_valid  (win_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic check(input string tag, input int idx, input vec_t e);
        logic [27:0] got;
        logic [27:0] exp;
        got = {wr_en, wr_addr, rd_addr, wr_data, hsel, win_valid, frame_done, busy, pix.in_ready};
        exp = {e.wr_en, e.addr, e.addr, e.data, e.hsel, e.win, e.done, e.busy, e.rdy};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got wr_en=%b wa=%0d ra=%0d wd=%h hsel=%0d wv=%b fd=%b busy=%b rdy=%b required wr_en=%b addr=%0d wd=%h hsel=%0d wv=%b fd=%b busy=%b rdy=%b",
                     tag, idx, wr_en, wr_addr, rd_addr, wr_data, hsel, win_valid, frame_done, busy,
                     pix.in_ready, e.wr_en, e.addr, e.data, e.hsel, e.win, e.done, e.busy, e.rdy);
        end else begin
            $display("ok   %s[%0d] wr_en=%b addr=%0d wd=%h hsel=%0d wv=%b fd=%b busy=%b rdy=%b",
                     tag, idx, wr_en, wr_addr, wr_data, hsel, win_valid, frame_done, busy, pix.in_ready);
        end
    endtask

    function automatic vec_t idle_vec(input logic valid, input logic sof, input logic [7:0] din);
        vec_t v;
        v.valid = valid; v.sof = sof; v.din = din;
        v.wr_en = 5'd0; v.addr = h_addr; v.data = h_data; v.win = 1'b0; v.hsel = h_hsel;
        v.rdy = 1'b1; v.done = 1'b0; v.busy = 1'b0;
        return v;
    endfunction

    // Expected sequence for n pixels of a frame (first pixel carries sof); a full frame adds flush + done.
    task automatic build_frame(input int n, input bit gapped);
        vec_t v;
        int   r;
        int   c;
        frame_id++;
        for (int p = 0; p < n; p++) begin
            r = p / W;
            c = p % W;
            v.valid = 1'b1;
            v.sof   = (p == 0);
            v.din   = 8'((p * 13 + frame_id * 7 + 5) & 255);
            v.wr_en = 5'b00001 << (r % 5);
            v.addr  = AW'(c);
            v.data  = v.din;
            v.win   = (r >= 4);
            if (r == 4) h_hsel = 3'd0;
            if (r == 5) h_hsel = 3'd1;
            v.hsel  = h_hsel;
            v.rdy   = (p != W * H - 1);
            v.done  = 1'b0;
            v.busy  = 1'b1;
            vq.push_back(v);
            h_addr = v.addr;
            h_data = v.data;
            if (gapped && p != W * H - 1) begin
                v.valid = 1'b0; v.sof = 1'b0; v.din = 8'hA5;
                v.wr_en = 5'd0; v.win = 1'b0; v.rdy = 1'b1;
                vq.push_back(v);
            end
        end
        if (n == W * H) begin
            for (int k = 0; k < 5; k++) begin
                // Offer pixels during flush: they must be refused.
                v.valid = 1'b1; v.sof = (k == 2); v.din = 8'h3C;
                v.wr_en = 5'd0; v.addr = h_addr; v.data = h_data; v.win = 1'b1;
                v.hsel = h_hsel; v.rdy = 1'b0; v.done = 1'b0; v.busy = 1'b1;
                vq.push_back(v);
            end
            v.valid = 1'b0; v.sof = 1'b0; v.din = 8'h00;
            v.wr_en = 5'd0; v.win = 1'b0; v.rdy = 1'b1; v.done = 1'b1; v.busy = 1'b0;
            vq.push_back(v);
        end
    endtask

    task automatic run_queue(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            pix.in_valid = vq[i].valid;
            pix.in_sof   = vq[i].sof;
            pix.din      = vq[i].din;
            @(posedge clock);
            #1;
            check(tag, i, vq[i]);
        end
        vq.delete();
    endtask

    initial begin
        vec_t z;
        pix.in_valid = 1'b0;
        pix.in_sof   = 1'b0;
        pix.din      = 8'd0;
        h_addr = '0; h_data = 8'd0; h_hsel = 3'd0;

        // Reset held with random traffic.
        z = idle_vec(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            pix.in_valid = 1'($urandom_range(0, 1));
            pix.in_sof   = 1'($urandom_range(0, 1));
            pix.din      = 8'($urandom_range(0, 255));
            @(posedge clock);
            #1;
            check("reset", i, z);
        end
        @(negedge clock);
        reset        = 1'b1;
        pix.in_valid = 1'b0;
        pix.in_sof   = 1'b0;

        for (int i = 0; i < 10; i++) vq.push_back(idle_vec(1'b1, 1'b0, 8'(i + 100)));
        run_queue("idle_nosof");

        build_frame(W * H, 1'b0);
        run_queue("frame_cont");

        // Sof on the cycle right after frame_done.
        build_frame(W * H, 1'b0);
        run_queue("frame_b2b");

        build_frame(W * H, 1'b1);
        run_queue("frame_gap");

        // Abort at row 2 col 3, then a complete frame.
        build_frame(2 * W + 3, 1'b0);
        build_frame(W * H, 1'b0);
        run_queue("abort");

        // Asynchronous reset while in RUN, between edges.
        build_frame(4 * W + 3, 1'b0);
        run_queue("pre_areset");
        #2;
        reset = 1'b0;
        #1;
        h_addr = '0; h_data = 8'd0; h_hsel = 3'd0;
        check("areset", 0, idle_vec(1'b0, 1'b0, 8'd0));
        @(negedge clock);
        reset        = 1'b1;
        pix.in_valid = 1'b0;
        pix.in_sof   = 1'b0;
        @(posedge clock);
        #1;
        check("areset", 1, idle_vec(1'b0, 1'b0, 8'd0));

        build_frame(W * H, 1'b0);
        run_queue("post_areset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_rotate_ctrl.md
Name: line_rotate_ctrl

Overview:
Sequencing controller for the 5-line vertical window filter (5-tap Gaussian, coefficient rotation via hsel). It accepts a raster pixel stream and drives five rotating line-buffer RAMs: write slot, write/read address and write data. It supplies the window datapath with hsel and validin (win_valid). After the last pixel it stalls upstream and flushes the window's 5-stage pipeline, since that pipeline advances only on validin.

Parameters:
WIDTH, 640, pixels per line (>=2)
HEIGHT, 480, lines per frame (>=5)
AW, 10, column/address width; 2^AW >= WIDTH
RW, 10, row counter width; 2^RW >= HEIGHT

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  pixel present on din
in_sof  in  1  qualifies din as first pixel of frame (valid only with in_valid)
din  in  8  pixel
in_ready  out  1  controller accepts pixel; transfer = in_valid & in_ready
wr_en  out  5  one-hot line-buffer slot write enable
wr_addr  out  AW  write column
wr_data  out  8  registered din
rd_addr  out  AW  read column (equals wr_addr)
hsel  out  3  coefficient rotation to window, 0..4
win_valid  out  1  validin to window
frame_done  out  1  one-cycle pulse at end of flush
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, col=0, row=0, wp=0, flush_cnt=0; wr_en=0, wr_addr=0, rd_addr=0, wr_data=0, hsel=0, win_valid=0, frame_done=0, busy=0. in_ready=1 in IDLE.
- in_ready = (state != FLUSH), decoded from the state register. All other outputs are registered, with 1-cycle latency from the accepting edge.
- States:
  - IDLE: transfers without in_sof are dropped; no output change. A transfer with in_sof sets wp=0, row=0, processes that pixel as col 0, then goes to FILL.
  - FILL (rows 0..3): each transfer gives wr_en=1<<wp, wr_addr=rd_addr=col, wr_data=din, win_valid=0.
  - RUN (rows 4..HEIGHT-1): same writes, plus win_valid=1 and hsel=(wp+1) mod 5. hsel is registered with the pixel. The newest line occupies slot wp; hsel=0 corresponds to wp=4.
  - FLUSH: win_valid=1 and wr_en=0 for exactly 5 cycles; hsel holds the last RUN value; in_ready=0. After the 5th cycle go to IDLE with frame_done=1 for one cycle.
- Cycles without a transfer (outside FLUSH): wr_en=0, win_valid=0. Addresses, hsel and wr_data hold.
- Column/row update: col increments per transfer. At col=WIDTH-1, col wraps to 0, row increments and wp=(wp+1) mod 5. FILL→RUN when row becomes 4. On the last pixel (row=HEIGHT-1, col=WIDTH-1) go RUN→FLUSH; row and wp then reset to 0.
- Mid-frame in_sof in FILL or RUN: abort the current frame and restart exactly as from IDLE (wp=0, row=0, pixel is col 0). No frame_done for the aborted frame.
- Mid-line in_sof in FILL/RUN still only resets counters; no partial-line flush.
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is discarded.
- frame_done and an in_sof transfer in the same cycle (IDLE entry edge) are legal; the new frame starts normally.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0, in_ready=1, busy=0; release, no activity until in_sof.
- Full frame, WIDTH=8, HEIGHT=6, continuous in_valid (48 pixels):
  - wr_en = 00001 x8, 00010 x8, 00100 x8, 01000 x8, 10000 x8, 00001 x8; wr_addr 0..7 repeating.
  - win_valid=1 for the last 16 pixels: hsel=0 for row 4, hsel=1 for row 5.
  - Then 5 cycles of win_valid=1, in_ready=0, hsel=1, wr_en=0; then frame_done=1 for one cycle, busy=0.
- Gapped input (in_valid toggling 1,0) in the same frame → identical write sequence, wr_en/win_valid low on gap cycles, addresses held; flush still exactly 5 cycles.
- IDLE pixels without in_sof (10 transfers) → no wr_en, busy stays 0. Mid-frame in_sof at row 2 col 3 → next output wr_en=00001, wr_addr=0, win_valid=0, and the frame completes 48 pixels later.
- Asynchronous reset asserted in RUN between clock edges → outputs 0 immediately. Back-to-back frames (in_sof on the cycle after frame_done) → second frame starts at slot 0 with a correct, identical sequence.
